mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 34 +++
 rtl/mdu_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
//------------------------------------------------------------------------------
// mdu_ctrl_if
// Handshake and operand/result bundle between the pipeline and the
// multiply/divide unit.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mdu_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues requests, observes status and results
    modport master (
        output start, op, a, b, flush,
        input  ready, busy, done, hi, lo
    );

    // Unit side
    modport slave (
        input  start, op, a, b, flush,
        output ready, busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_ctrl.sv
//------------------------------------------------------------------------------
// mdu_ctrl
// MIPS-style HI/LO multiply/divide unit controller. Multiply completes in two
// cycles after accept; divide runs a 32-iteration restoring divider on operand
// magnitudes followed by a sign-fixup cycle.
// Optional feature macro: MDU_DIV_EN (defined -> divider present; undefined ->
// DIV/DIVU complete immediately and leave HI/LO untouched).
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_ctrl (
    input  logic      clk,
    input  logic      resetn,
    mdu_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
`ifdef MDU_DIV_EN
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;       // 1 = signed operation (op[0]==0)
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        w_ready;
    logic        w_accept;
    logic [63:0] w_prod;

`ifdef MDU_DIV_EN
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;       // partial remainder
    logic [31:0] quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
    logic [31:0] dvsr_q, dvsr_d;     // divisor magnitude
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;

    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_amag;
    logic [31:0] w_bmag;
    logic        w_sgn_in;

    // Operand magnitudes at accept time (signed ops only fold negative values)
    assign w_sgn_in = ~bus.op[0];
    assign w_amag   = (w_sgn_in & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_bmag   = (w_sgn_in & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // One restoring step: shift next dividend bit in, subtract if it fits
    assign w_shift  = {rem_q, quo_q[31]};
    assign w_ge     = (w_shift >= {1'b0, dvsr_q});
    assign w_sub    = w_shift[31:0] - dvsr_q;
`endif

    assign w_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign w_accept = bus.start & w_ready & ~bus.flush;

    // Single 64x64 multiplier; sign extension selects MULT vs MULTU
    assign w_prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_DIV_EN
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif

        case (state_q)
            S_MUL: begin
                hi_d    = w_prod[63:32];
                lo_d    = w_prod[31:0];
                state_d = S_DONE;
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
                if (w_ge) begin
                    rem_d = w_sub;
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = w_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                // Zero divisor: all-ones quotient, dividend passed back as remainder
                if (dvsr_q == 32'd0) begin
                    lo_d = 32'hFFFF_FFFF;
                    hi_d = a_q;
                end else begin
                    lo_d = negq_q ? (~quo_q + 32'd1) : quo_q;
                    hi_d = negr_q ? (~rem_q + 32'd1) : rem_q;
                end
                state_d = S_DONE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            sgn_d = ~bus.op[0];
            if (bus.op[1]) begin
`ifdef MDU_DIV_EN
                state_d = S_DIV;
                cnt_d   = 5'd0;
                rem_d   = 32'd0;
                quo_d   = w_amag;
                dvsr_d  = w_bmag;
                negq_d  = w_sgn_in & (bus.a[31] ^ bus.b[31]);
                negr_d  = w_sgn_in & bus.a[31];
`else
                state_d = S_DONE;
`endif
            end else begin
                state_d = S_MUL;
            end
        end

        // Abort: return to idle and keep the previously committed HI/LO
        if (bus.flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_DIV_EN
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign bus.ready = w_ready;
`ifdef MDU_DIV_EN
    assign bus.busy  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIN);
`else
    assign bus.busy  = (state_q == S_MUL);
`endif
    assign bus.done  = (state_q == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
//------------------------------------------------------------------------------
// tb_mdu_ctrl
// Directed self-checking bench for mdu_ctrl. Adapts its divide expectations
// to whether MDU_DIV_EN is defined.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu_ctrl;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    int   lat;
    bit   busy_ok;

    mdu_ctrl_if bus ();

    mdu_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble operands after accept, wait for done (bounded)
    task automatic do_op(input logic [1:0] op_v, input logic [31:0] a_v,
                         input logic [31:0] b_v, output int l, output bit bok);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        step();
        bus.start = 1'b0;
        bus.a     = ~a_v;
        bus.b     = ~b_v;
        l   = 1;
        bok = 1'b1;
        while (bus.done !== 1'b1 && l < 100) begin
            if (bus.busy !== 1'b1) bok = 1'b0;
            step();
            l++;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.flush = 1'b0;
        resetn    = 1'b1;

        // Asynchronous reset state
        #2 resetn = 1'b0;
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_done",  bus.done,  0);
        chk("rst_hi",    bus.hi,    0);
        chk("rst_lo",    bus.lo,    0);
        step();
        step();
        resetn = 1'b1;
        step();

        // MULT -2 * 3
        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat, busy_ok);
        chk("mult_lat",  lat, 2);
        chk("mult_busy", busy_ok, 1);
        chk("mult_hi",   bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo",   bus.lo, 32'hFFFF_FFFA);

        // MULTU same operands, accepted back-to-back in DONE
        do_op(2'b01, 32'hFFFF_FFFE, 32'd3, lat, busy_ok);
        chk("multu_lat", lat, 2);
        chk("multu_hi",  bus.hi, 32'h0000_0002);
        chk("multu_lo",  bus.lo, 32'hFFFF_FFFA);

        // Start held during busy with changing operands is ignored
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'd6;
        step();
        bus.a = 32'd100; bus.b = 32'd100;
        chk("hold_busy", bus.busy, 1);
        step();
        bus.start = 1'b0;
        chk("hold_done", bus.done, 1);
        chk("hold_hi",   bus.hi, 0);
        chk("hold_lo",   bus.lo, 32'd42);
        step();
        chk("hold_idle", bus.ready, 1);

        // start + flush same cycle: nothing accepted
        bus.start = 1'b1; bus.flush = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("sf_ready", bus.ready, 1);
        chk("sf_busy",  bus.busy,  0);
        step();
        chk("sf_done",  bus.done,  0);
        chk("sf_lo",    bus.lo,    32'd42);

        // Flush during MUL: no done, HI/LO keep prior values
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
        step();
        bus.start = 1'b0; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fm_busy", bus.busy, 0);
        chk("fm_done", bus.done, 0);
        step();
        chk("fm_done2", bus.done, 0);
        chk("fm_hi",    bus.hi, 0);
        chk("fm_lo",    bus.lo, 32'd42);

        // MULTU max operands, then flush (with start) while in DONE
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_ok);
        chk("mx_lat", lat, 2);
        chk("mx_hi",  bus.hi, 32'hFFFF_FFFE);
        chk("mx_lo",  bus.lo, 32'h0000_0001);
        bus.flush = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3;
        #1;
        chk("fd_keep_done", bus.done, 1);
        step();
        bus.flush = 1'b0; bus.start = 1'b0;
        chk("fd_done", bus.done,  0);
        chk("fd_busy", bus.busy,  0);
        chk("fd_lo",   bus.lo,    32'h0000_0001);

`ifdef MDU_DIV_EN
        // DIV -7 / 2
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busy_ok);
        chk("div_lat",  lat, 34);
        chk("div_busy", busy_ok, 1);
        chk("div_lo",   bus.lo, 32'hFFFF_FFFD);
        chk("div_hi",   bus.hi, 32'hFFFF_FFFF);

        // DIVU 100 / 7 back-to-back
        do_op(2'b11, 32'd100, 32'd7, lat, busy_ok);
        chk("divu_lat", lat, 34);
        chk("divu_lo",  bus.lo, 32'd14);
        chk("divu_hi",  bus.hi, 32'd2);

        // DIVU 5 / 0
        do_op(2'b11, 32'd5, 32'd0, lat, busy_ok);
        chk("dz_lat", lat, 34);
        chk("dz_lo",  bus.lo, 32'hFFFF_FFFF);
        chk("dz_hi",  bus.hi, 32'd5);

        // DIV -2^31 / -1
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ok);
        chk("ov_lat", lat, 34);
        chk("ov_lo",  bus.lo, 32'h8000_0000);
        chk("ov_hi",  bus.hi, 32'd0);
        step();

        // DIV flushed in cycle N+10: idle at N+11, no done through N+40
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("df_ready", bus.ready, 1);
        chk("df_busy",  bus.busy,  0);
        begin
            bit seen_done;
            seen_done = 1'b0;
            for (int i = 0; i < 30; i++) begin
                if (bus.done === 1'b1) seen_done = 1'b1;
                step();
            end
            chk("df_no_done", seen_done, 0);
        end
        chk("df_hi", bus.hi, 32'd0);
        chk("df_lo", bus.lo, 32'h8000_0000);

        // Reset pulsed in cycle N+5 of a DIV
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd5;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
`else
        // Without the divider, DIVU/DIV finish at N+1 with HI/LO unchanged
        do_op(2'b11, 32'd100, 32'd7, lat, busy_ok);
        chk("ndivu_lat", lat, 1);
        chk("ndivu_hi",  bus.hi, 32'hFFFF_FFFE);
        chk("ndivu_lo",  bus.lo, 32'h0000_0001);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busy_ok);
        chk("ndiv_lat",  lat, 1);
        chk("ndiv_lo",   bus.lo, 32'h0000_0001);

        // Reset pulsed in the middle of a MUL
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd11; bus.b = 32'd11;
        step();
        bus.start = 1'b0;
`endif
        #2 resetn = 1'b0;
        #1;
        chk("mr_hi",    bus.hi,    0);
        chk("mr_lo",    bus.lo,    0);
        chk("mr_ready", bus.ready, 1);
        chk("mr_busy",  bus.busy,  0);
        chk("mr_done",  bus.done,  0);
        resetn = 1'b1;
        step();

        // First operation after reset behaves as from power-up
        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat, busy_ok);
        chk("pr_lat", lat, 2);
        chk("pr_hi",  bus.hi, 32'hFFFF_FFFF);
        chk("pr_lo",  bus.lo, 32'hFFFF_FFFA);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
